// File: rtl/mem_access.sv
// Memory-access stage: aligns loads/stores onto a 32-bit valid/ready bus,
// extends load data for write-back and stalls upstream while busy.
module mem_access (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] alu_result,
    input  logic [31:0] reg2_data,
    input  logic        memory_read_enable,
    input  logic        memory_write_enable,
    input  logic [2:0]  funct3,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic [31:0] bus_address,
    output logic        bus_write,
    output logic [31:0] bus_write_data,
    output logic [3:0]  bus_write_strobe,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_bvalid,
    output logic [31:0] memory_read_data,
    output logic        ctrl_stall,
    output logic        done,
    output logic        mem_fault
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] REQUEST   = 2'd1;
    localparam logic [1:0] WAIT_RESP = 2'd2;
    localparam logic [1:0] COMPLETE  = 2'd3;

    logic [1:0]  state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  strb_q;
    logic [2:0]  f3_q;
    logic        write_q;
    logic [31:0] rdata_q;
    logic        fault_q;

    logic        any_en;
    logic        misaligned;
    logic [31:0] st_data;
    logic [3:0]  st_strb;
    logic [31:0] shifted;
    logic [31:0] ld_ext;

    assign any_en = memory_read_enable | memory_write_enable;

    // funct3[1:0]: 00 byte, 01 half, anything else is treated as a word
    assign misaligned = (funct3[1:0] == 2'b01 && alu_result[0])
                      || (funct3[1] && alu_result[1:0] != 2'b00);

    always_comb begin
        st_strb = 4'b1111;
        st_data = reg2_data;
        case (funct3[1:0])
            2'b00: begin
                st_strb = 4'b0001 << alu_result[1:0];
                st_data = {4{reg2_data[7:0]}};
            end
            2'b01: begin
                st_strb = 4'b0011 << alu_result[1:0];
                st_data = {2{reg2_data[15:0]}};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = reg2_data;
            end
        endcase
    end

    assign shifted = bus_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        ld_ext = shifted;
        case (f3_q[1:0])
            2'b00: ld_ext = f3_q[2] ? {24'd0, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
            2'b01: ld_ext = f3_q[2] ? {16'd0, shifted[15:0]}
                                    : {{16{shifted[15]}}, shifted[15:0]};
            default: ld_ext = shifted;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            f3_q    <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            fault_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_en) begin
                        if (misaligned) begin
                            fault_q <= 1'b1;
                        end else begin
                            addr_q  <= alu_result;
                            wdata_q <= st_data;
                            strb_q  <= st_strb;
                            f3_q    <= funct3;
                            write_q <= memory_write_enable;
                            state   <= REQUEST;
                        end
                    end
                end
                REQUEST: begin
                    if (bus_ready) state <= WAIT_RESP;
                end
                WAIT_RESP: begin
                    // only the response matching the captured direction counts
                    if (write_q ? bus_bvalid : bus_rvalid) begin
                        if (!write_q) rdata_q <= ld_ext;
                        state <= COMPLETE;
                    end
                end
                COMPLETE: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    assign bus_valid        = !reset && state == REQUEST;
    assign bus_address      = reset ? 32'd0 : {addr_q[31:2], 2'b00};
    assign bus_write        = !reset && write_q;
    assign bus_write_data   = reset ? 32'd0 : wdata_q;
    assign bus_write_strobe = reset ? 4'd0 : strb_q;
    assign memory_read_data = reset ? 32'd0 : rdata_q;
    assign done             = !reset && state == COMPLETE;
    assign mem_fault        = !reset && fault_q;
    assign ctrl_stall       = !reset
                            && ((state == IDLE && any_en && !misaligned)
                            || state == REQUEST || state == WAIT_RESP);

endmodule

// File: tb/tb_mem_access.sv
// Testbench for mem_access: directed vector table, hand sequences for
// stall/reset corners, and randomized accesses against a byte-level model.
module tb_mem_access;

    logic        clock;
    logic        reset;
    logic [31:0] alu_result;
    logic [31:0] reg2_data;
    logic        memory_read_enable;
    logic        memory_write_enable;
    logic [2:0]  funct3;
    logic        bus_valid;
    logic        bus_ready;
    logic [31:0] bus_address;
    logic        bus_write;
    logic [31:0] bus_write_data;
    logic [3:0]  bus_write_strobe;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_bvalid;
    logic [31:0] memory_read_data;
    logic        ctrl_stall;
    logic        done;
    logic        mem_fault;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_rd = 32'd0;

    mem_access dut (
        .clock               (clock),
        .reset               (reset),
        .alu_result          (alu_result),
        .reg2_data           (reg2_data),
        .memory_read_enable  (memory_read_enable),
        .memory_write_enable (memory_write_enable),
        .funct3              (funct3),
        .bus_valid           (bus_valid),
        .bus_ready           (bus_ready),
        .bus_address         (bus_address),
        .bus_write           (bus_write),
        .bus_write_data      (bus_write_data),
        .bus_write_strobe    (bus_write_strobe),
        .bus_rvalid          (bus_rvalid),
        .bus_rdata           (bus_rdata),
        .bus_bvalid          (bus_bvalid),
        .memory_read_data    (memory_read_data),
        .ctrl_stall          (ctrl_stall),
        .done                (done),
        .mem_fault           (mem_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic bit model_misaligned(input logic [31:0] addr,
                                            input logic [2:0] f3);
        int a;
        a = int'(addr[1:0]);
        return (a % acc_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rdata,
                                               input logic [31:0] addr,
                                               input logic [2:0] f3);
        int a;
        int sz;
        logic [31:0] v;
        a  = int'(addr[1:0]);
        sz = acc_size(f3);
        v  = 32'd0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = rdata[8*(a+i) +: 8];
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
        return v;
    endfunction

    function automatic logic [3:0] model_strobe(input logic [31:0] addr,
                                                input logic [2:0] f3);
        int a;
        int sz;
        logic [3:0] s;
        a  = int'(addr[1:0]);
        sz = acc_size(f3);
        s  = 4'd0;
        for (int i = 0; i < 4; i++) if (i >= a && i < a + sz) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] wdata,
                                                input logic [2:0] f3);
        int sz;
        logic [31:0] d;
        sz = acc_size(f3);
        d  = 32'd0;
        for (int i = 0; i < 4; i++) d[8*i +: 8] = wdata[8*(i % sz) +: 8];
        return d;
    endfunction

    task automatic run_access(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic re,
                              input logic we, input logic [2:0] f3,
                              input logic [3:0] e_strb, input logic [31:0] e_wdata,
                              input logic [31:0] e_rd, input int rdly,
                              input int sdly, input logic noise,
                              input string tag);
        logic [31:0] e_addr;
        e_addr = {addr[31:2], 2'b00};
        @(negedge clock);
        alu_result = addr;
        reg2_data = wdata;
        memory_read_enable = re;
        memory_write_enable = we;
        funct3 = f3;
        bus_ready = 1'b0;
        bus_rvalid = 1'b0;
        bus_bvalid = 1'b0;
        #1;
        check({tag, " stall_c0"}, ctrl_stall, 1);
        check({tag, " valid_c0"}, bus_valid, 0);
        for (int k = 0; k <= rdly; k++) begin
            @(negedge clock);
            check({tag, " req_valid"}, bus_valid, 1);
            check({tag, " req_addr"}, bus_address, e_addr);
            check({tag, " req_write"}, bus_write, we);
            check({tag, " req_stall"}, ctrl_stall, 1);
            check({tag, " req_done"}, done, 0);
            if (we) begin
                check({tag, " req_strobe"}, bus_write_strobe, e_strb);
                check({tag, " req_wdata"}, bus_write_data, e_wdata);
            end
            bus_ready = (k == rdly);
            if (noise) begin
                bus_rvalid = 1'b1;
                bus_bvalid = 1'b1;
                bus_rdata = $urandom;
            end
        end
        for (int k = 0; k <= sdly; k++) begin
            @(negedge clock);
            bus_ready = 1'b0;
            check({tag, " wait_valid"}, bus_valid, 0);
            check({tag, " wait_stall"}, ctrl_stall, 1);
            check({tag, " wait_done"}, done, 0);
            bus_rdata = (k == sdly) ? rdata : $urandom;
            bus_rvalid = (k == sdly && !we) || (noise && we);
            bus_bvalid = (k == sdly && we) || (noise && !we);
        end
        @(negedge clock);
        bus_rvalid = 1'b0;
        bus_bvalid = 1'b0;
        check({tag, " done"}, done, 1);
        check({tag, " done_stall"}, ctrl_stall, 0);
        check({tag, " rdata"}, memory_read_data, e_rd);
        exp_rd = e_rd;
        memory_read_enable = 1'b0;
        memory_write_enable = 1'b0;
        @(negedge clock);
        check({tag, " done_once"}, done, 0);
        check({tag, " rdata_hold"}, memory_read_data, exp_rd);
        check({tag, " idle_valid"}, bus_valid, 0);
    endtask

    task automatic run_fault(input logic [31:0] addr, input logic re,
                             input logic we, input logic [2:0] f3,
                             input string tag);
        @(negedge clock);
        alu_result = addr;
        reg2_data = $urandom;
        memory_read_enable = re;
        memory_write_enable = we;
        funct3 = f3;
        bus_ready = 1'b1;
        #1;
        check({tag, " f_stall"}, ctrl_stall, 0);
        check({tag, " f_valid0"}, bus_valid, 0);
        @(negedge clock);
        check({tag, " f_pulse"}, mem_fault, 1);
        check({tag, " f_valid1"}, bus_valid, 0);
        check({tag, " f_done"}, done, 0);
        memory_read_enable = 1'b0;
        memory_write_enable = 1'b0;
        @(negedge clock);
        check({tag, " f_single"}, mem_fault, 0);
        check({tag, " f_valid2"}, bus_valid, 0);
        check({tag, " f_rdata"}, memory_read_data, exp_rd);
        bus_ready = 1'b0;
    endtask

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        re;
        logic        we;
        logic [2:0]  f3;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        logic [31:0] e_rd;
        logic        e_fault;
    } vec_t;

    vec_t vecs[13];

    initial begin
        reset = 1'b1;
        alu_result = '0;
        reg2_data = '0;
        memory_read_enable = 1'b0;
        memory_write_enable = 1'b0;
        funct3 = '0;
        bus_ready = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata = '0;
        bus_bvalid = 1'b0;

        vecs[0]  = '{32'h1003, 32'h0, 32'h80FF1234, 1'b1, 1'b0, 3'd0,
                     4'h0, 32'h0, 32'hFFFFFF80, 1'b0};
        vecs[1]  = '{32'h1001, 32'h0, 32'h80FF1234, 1'b1, 1'b0, 3'd4,
                     4'h0, 32'h0, 32'h00000012, 1'b0};
        vecs[2]  = '{32'h1002, 32'h0, 32'h80FF1234, 1'b1, 1'b0, 3'd1,
                     4'h0, 32'h0, 32'hFFFF80FF, 1'b0};
        vecs[3]  = '{32'h1002, 32'h0, 32'h80FF1234, 1'b1, 1'b0, 3'd5,
                     4'h0, 32'h0, 32'h000080FF, 1'b0};
        vecs[4]  = '{32'h1000, 32'h0, 32'h80FF1234, 1'b1, 1'b0, 3'd2,
                     4'h0, 32'h0, 32'h80FF1234, 1'b0};
        vecs[5]  = '{32'h1000, 32'h0, 32'h00017FFE, 1'b1, 1'b0, 3'd1,
                     4'h0, 32'h0, 32'h00007FFE, 1'b0};
        vecs[6]  = '{32'h2002, 32'h0000ABCD, 32'h0, 1'b0, 1'b1, 3'd1,
                     4'b1100, 32'hABCDABCD, 32'h0, 1'b0};
        vecs[7]  = '{32'h5001, 32'h112233A5, 32'h0, 1'b0, 1'b1, 3'd0,
                     4'b0010, 32'hA5A5A5A5, 32'h0, 1'b0};
        vecs[8]  = '{32'h4000, 32'h12345678, 32'h0, 1'b1, 1'b1, 3'd2,
                     4'b1111, 32'h12345678, 32'h0, 1'b0};
        vecs[9]  = '{32'h3001, 32'h0, 32'h0, 1'b1, 1'b0, 3'd1,
                     4'h0, 32'h0, 32'h0, 1'b1};
        vecs[10] = '{32'h3002, 32'h0, 32'h0, 1'b1, 1'b0, 3'd2,
                     4'h0, 32'h0, 32'h0, 1'b1};
        vecs[11] = '{32'h3003, 32'h0, 32'h0, 1'b0, 1'b1, 3'd1,
                     4'h0, 32'h0, 32'h0, 1'b1};
        vecs[12] = '{32'h1000, 32'h0, 32'h0000007F, 1'b1, 1'b0, 3'd0,
                     4'h0, 32'h0, 32'h0000007F, 1'b0};

        repeat (2) @(negedge clock);
        check("rst_valid", bus_valid, 0);
        check("rst_addr", bus_address, 0);
        check("rst_strobe", bus_write_strobe, 0);
        check("rst_rdata", memory_read_data, 0);
        check("rst_stall", ctrl_stall, 0);
        check("rst_done", done, 0);
        check("rst_fault", mem_fault, 0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].e_fault)
                run_fault(vecs[i].addr, vecs[i].re, vecs[i].we, vecs[i].f3,
                          $sformatf("vec%0d", i));
            else
                run_access(vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
                           vecs[i].re, vecs[i].we, vecs[i].f3,
                           vecs[i].e_strb, vecs[i].e_wdata,
                           vecs[i].we ? exp_rd : vecs[i].e_rd,
                           0, 0, 1'b0, $sformatf("vec%0d", i));
        end

        // bus_ready held low for 5 cycles, stray responses while requesting
        run_access(32'h6004, 32'h0, 32'hCAFEF00D, 1'b1, 1'b0, 3'd2,
                   4'h0, 32'h0, 32'hCAFEF00D, 5, 2, 1'b1, "stall_lw");

        // reset while waiting for the response; the late rvalid is dropped
        @(negedge clock);
        alu_result = 32'h1000;
        memory_read_enable = 1'b1;
        funct3 = 3'd2;
        @(negedge clock);
        bus_ready = 1'b1;
        @(negedge clock);
        bus_ready = 1'b0;
        check("rw_stall", ctrl_stall, 1);
        reset = 1'b1;
        @(negedge clock);
        check("rw_valid", bus_valid, 0);
        check("rw_stall_rst", ctrl_stall, 0);
        check("rw_done", done, 0);
        check("rw_rdata", memory_read_data, 0);
        check("rw_addr", bus_address, 0);
        check("rw_write", bus_write, 0);
        memory_read_enable = 1'b0;
        reset = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata = 32'hDEADBEEF;
        @(negedge clock);
        check("rw_late_done", done, 0);
        check("rw_late_rdata", memory_read_data, 0);
        @(negedge clock);
        check("rw_idle_done", done, 0);
        check("rw_idle_valid", bus_valid, 0);
        check("rw_idle_stall", ctrl_stall, 0);
        bus_rvalid = 1'b0;
        exp_rd = 32'd0;

        for (int i = 0; i < 40; i++) begin
            logic we;
            logic re;
            logic [2:0] f3;
            logic [31:0] addr;
            logic [31:0] wdata;
            logic [31:0] rdata;
            logic [2:0] ld_f3s[5];
            ld_f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            we = 1'($urandom_range(0, 1));
            re = we ? 1'($urandom_range(0, 1)) : 1'b1;
            f3 = we ? 3'($urandom_range(0, 2)) : ld_f3s[$urandom_range(0, 4)];
            addr = $urandom;
            if ($urandom_range(0, 3) != 0)
                addr = addr & ~32'(acc_size(f3) - 1);
            wdata = $urandom;
            rdata = $urandom;
            if (model_misaligned(addr, f3))
                run_fault(addr, re, we, f3, $sformatf("rnd%0d", i));
            else
                run_access(addr, wdata, rdata, re, we, f3,
                           model_strobe(addr, f3), model_wdata(wdata, f3),
                           we ? exp_rd : model_load(rdata, addr, f3),
                           $urandom_range(0, 3), $urandom_range(0, 3),
                           1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
